// File: rtl/vending_pkg.sv
// Shared types and helpers for the vending controller.
//   vend_state_t  : controller states (idle, credit held, dispensing, returning change)
//   item_price()  : extracts one price from a packed price table
package vending_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCredit,
      StDispense,
      StChange
   } vend_state_t;

   // Widest packed price table item_price() can index.
   localparam int unsigned PriceTableMax = 1024;

   // Returns the price of item idx from a table of width-bit entries, item 0 in the LSBs.
   // An out-of-range idx shifts past the table and yields 0.
   function automatic logic [31:0] item_price(input logic [PriceTableMax-1:0] prices,
                                              input int unsigned idx,
                                              input int unsigned width);
      logic [31:0] mask;
      mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
      return 32'(prices >> (idx * width)) & mask;
   endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter that times the dispense phase.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   load_i  : load the counter with CYCLES
//   done_o  : high during the last counted cycle
module vend_timer #(
   parameter int unsigned CYCLES = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   output logic done_o
);

   localparam int unsigned CNT_W = $clog2(CYCLES + 1);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else if (load_i) begin
         r_cnt <= LOAD_VAL;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // Loaded on the select edge, so the count reads CYCLES..1 over the dispense cycles.
   assign done_o = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/vending_controller.sv
// Multi-item vending controller: accumulates coin credit, dispenses a selected item
// against a price table, then returns change; cancel refunds the whole credit.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   coin_valid_i/value  : coin strobe and value
//   sel_valid_i, sel_i  : selection strobe and item index
//   cancel_i            : refund request
//   total_o, busy_o     : current credit, dispense/change in progress
//   coin_reject_o       : pulse, coin not accepted
//   sel_err_o           : pulse, selection refused
//   dispense_o/item_o   : dispense actuator and item being dispensed
//   change_valid_o/o    : change strobe and amount
// All outputs come straight from flops.
module vending_controller
   import vending_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N_ITEMS = 4,
   parameter logic [N_ITEMS*WIDTH-1:0] PRICES = {8'd150, 8'd100, 8'd75, 8'd50},
   parameter int unsigned DISPENSE_CYCLES = 3,
   localparam int unsigned SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             coin_valid_i,
   input  logic [WIDTH-1:0] coin_value_i,
   input  logic             sel_valid_i,
   input  logic [SEL_W-1:0] sel_i,
   input  logic             cancel_i,
   output logic [WIDTH-1:0] total_o,
   output logic             busy_o,
   output logic             coin_reject_o,
   output logic             sel_err_o,
   output logic             dispense_o,
   output logic [SEL_W-1:0] dispense_item_o,
   output logic             change_valid_o,
   output logic [WIDTH-1:0] change_o
);

   localparam logic [PriceTableMax-1:0] PRICES_EXT = PriceTableMax'(PRICES);

   vend_state_t      r_state, w_state_d;
   logic [WIDTH-1:0] r_total, w_total_d;
   logic [WIDTH-1:0] r_change, w_change_d;
   logic [SEL_W-1:0] r_item, w_item_d;
   logic             r_coin_reject, w_coin_reject_d;
   logic             r_sel_err, w_sel_err_d;
   logic             r_dispense, r_change_valid, r_busy;

   logic             w_load;
   logic             w_timer_done;
   logic             w_sel_ok;
   logic [WIDTH-1:0] w_price;
   logic [WIDTH:0]   w_sum;

   vend_timer #(
      .CYCLES (DISPENSE_CYCLES)
   ) u_timer (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (w_load),
      .done_o (w_timer_done)
   );

   assign w_sel_ok = (32'(sel_i) < N_ITEMS);
   assign w_price  = WIDTH'(item_price(PRICES_EXT, 32'(sel_i), WIDTH));
   // One extra bit so overflow past 2^WIDTH-1 is visible as the carry.
   assign w_sum    = {1'b0, r_total} + {1'b0, coin_value_i};

   always_comb begin
      w_state_d       = r_state;
      w_total_d       = r_total;
      w_change_d      = r_change;
      w_item_d        = r_item;
      w_coin_reject_d = 1'b0;
      w_sel_err_d     = 1'b0;
      w_load          = 1'b0;

      unique case (r_state)
         StIdle, StCredit: begin
            // Priority cancel > select > coin; a coin losing to either is rejected.
            // Cancel with no credit is not an event, so select/coin still proceed.
            if (cancel_i && (r_state == StCredit)) begin
               w_state_d       = StChange;
               w_change_d      = r_total;
               w_coin_reject_d = coin_valid_i;
            end else if (sel_valid_i) begin
               w_coin_reject_d = coin_valid_i;
               if (!w_sel_ok || (r_total < w_price)) begin
                  w_sel_err_d = 1'b1;
               end else begin
                  w_state_d  = StDispense;
                  w_item_d   = sel_i;
                  w_change_d = r_total - w_price;
                  w_load     = 1'b1;
               end
            end else if (coin_valid_i) begin
               if (w_sum[WIDTH]) begin
                  w_coin_reject_d = 1'b1;
               end else begin
                  w_total_d = w_sum[WIDTH-1:0];
                  // A zero coin in idle leaves the state alone.
                  if (w_sum[WIDTH-1:0] != '0) begin
                     w_state_d = StCredit;
                  end
               end
            end
         end
         StDispense: begin
            w_coin_reject_d = coin_valid_i;
            if (w_timer_done) begin
               w_state_d = StChange;
            end
         end
         StChange: begin
            w_coin_reject_d = coin_valid_i;
            w_state_d       = StIdle;
            w_total_d       = '0;
            w_change_d      = '0;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state        <= StIdle;
         r_total        <= '0;
         r_change       <= '0;
         r_item         <= '0;
         r_coin_reject  <= 1'b0;
         r_sel_err      <= 1'b0;
         r_dispense     <= 1'b0;
         r_change_valid <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_state        <= w_state_d;
         r_total        <= w_total_d;
         r_change       <= w_change_d;
         r_item         <= w_item_d;
         r_coin_reject  <= w_coin_reject_d;
         r_sel_err      <= w_sel_err_d;
         // Status outputs registered from the next state so they align with it.
         r_dispense     <= (w_state_d == StDispense);
         r_change_valid <= (w_state_d == StChange);
         r_busy         <= (w_state_d == StDispense) || (w_state_d == StChange);
      end
   end

   assign total_o         = r_total;
   assign busy_o          = r_busy;
   assign coin_reject_o   = r_coin_reject;
   assign sel_err_o       = r_sel_err;
   assign dispense_o      = r_dispense;
   assign dispense_item_o = r_item;
   assign change_valid_o  = r_change_valid;
   assign change_o        = r_change;

endmodule

// File: tb/tb_vending_controller.sv
// Bench for vending_controller: directed scenarios plus random coin/select/cancel traffic.
// A driver applies one cycle of stimulus per negedge and schedules the expected outputs
// into a queue; a monitor pops and compares them after every active edge.
module tb_vending_controller;

   localparam int W    = 8;
   localparam int N    = 4;
   localparam int D    = 3;
   localparam int MAXC = 255;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         coin_valid_i;
   logic [W-1:0] coin_value_i;
   logic         sel_valid_i;
   logic [1:0]   sel_i;
   logic         cancel_i;
   logic [W-1:0] total_o;
   logic         busy_o;
   logic         coin_reject_o;
   logic         sel_err_o;
   logic         dispense_o;
   logic [1:0]   dispense_item_o;
   logic         change_valid_o;
   logic [W-1:0] change_o;

   vending_controller #(
      .WIDTH           (8),
      .N_ITEMS         (4),
      .PRICES          ({8'd150, 8'd100, 8'd75, 8'd50}),
      .DISPENSE_CYCLES (3)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .coin_valid_i    (coin_valid_i),
      .coin_value_i    (coin_value_i),
      .sel_valid_i     (sel_valid_i),
      .sel_i           (sel_i),
      .cancel_i        (cancel_i),
      .total_o         (total_o),
      .busy_o          (busy_o),
      .coin_reject_o   (coin_reject_o),
      .sel_err_o       (sel_err_o),
      .dispense_o      (dispense_o),
      .dispense_item_o (dispense_item_o),
      .change_valid_o  (change_valid_o),
      .change_o        (change_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int total;
      bit busy;
      bit rej;
      bit err;
      bit disp;
      int item;
      bit cv;
      int chg;
   } exp_t;

   // One future output cycle of a dispense/change sequence.
   typedef struct {
      bit disp;
      int item;
      bit cv;
      int chg;
   } frame_t;

   exp_t   exp_q[$];
   frame_t sched[$];

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int m_credit     = 0;
   bit m_busy       = 1'b0;
   bit m_cur_change = 1'b0;

   int prices[N]    = '{50, 75, 100, 150};
   int coin_tab[7]  = '{0, 5, 10, 25, 50, 100, 200};

   task automatic chk(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic model_reset();
      sched.delete();
      m_credit     = 0;
      m_busy       = 1'b0;
      m_cur_change = 1'b0;
   endtask

   // Apply one cycle of stimulus and schedule the outputs expected after the next edge.
   task automatic step(input bit cv, input int cval, input bit sv, input int s, input bit can);
      exp_t   e;
      frame_t f;
      bit     rej;
      bit     err;
      rej = 1'b0;
      err = 1'b0;
      @(negedge clk_i);
      coin_valid_i = cv;
      coin_value_i = W'(cval);
      sel_valid_i  = sv;
      sel_i        = 2'(s);
      cancel_i     = can;

      // Credit is spent once the change cycle has been shown.
      if (m_cur_change) m_credit = 0;

      if (m_busy) begin
         rej = cv;
      end else if (can && m_credit > 0) begin
         sched.push_back('{1'b0, 0, 1'b1, m_credit});
         rej = cv;
      end else if (sv) begin
         rej = cv;
         if (s >= N || m_credit < prices[s]) begin
            err = 1'b1;
         end else begin
            for (int i = 0; i < D; i++) sched.push_back('{1'b1, s, 1'b0, 0});
            sched.push_back('{1'b0, 0, 1'b1, m_credit - prices[s]});
         end
      end else if (cv) begin
         if (m_credit + cval > MAXC) rej = 1'b1;
         else m_credit += cval;
      end

      if (sched.size() > 0) f = sched.pop_front();
      else f = '{1'b0, 0, 1'b0, 0};
      m_busy       = f.disp || f.cv;
      m_cur_change = f.cv;
      e = '{m_credit, m_busy, rej, err, f.disp, f.item, f.cv, f.chg};
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 1'b0);
   endtask

   // Monitor
   initial begin
      exp_t e;
      bit   ok;
      forever begin
         @(posedge clk_i);
         #1;
         if (!rst_i && exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ok = (int'(total_o) == e.total) && (busy_o == e.busy) &&
                 (coin_reject_o == e.rej) && (sel_err_o == e.err) &&
                 (dispense_o == e.disp) && (!e.disp || int'(dispense_item_o) == e.item) &&
                 (change_valid_o == e.cv) && (!e.cv || int'(change_o) == e.chg);
            n_vec++;
            if (!ok) begin
               n_err++;
               $display({"FAIL cycle t=%0t: got total=%0d busy=%0b rej=%0b err=%0b disp=%0b ",
                         "item=%0d cv=%0b chg=%0d; expected total=%0d busy=%0b rej=%0b err=%0b ",
                         "disp=%0b item=%0d cv=%0b chg=%0d"},
                        $time, total_o, busy_o, coin_reject_o, sel_err_o, dispense_o,
                        dispense_item_o, change_valid_o, change_o, e.total, e.busy, e.rej,
                        e.err, e.disp, e.item, e.cv, e.chg);
            end
         end
      end
   end

   // Driver
   initial begin
      rst_i        = 1'b1;
      coin_valid_i = 1'b0;
      coin_value_i = '0;
      sel_valid_i  = 1'b0;
      sel_i        = '0;
      cancel_i     = 1'b0;
      #12;
      chk("reset total_o", int'(total_o), 0);
      chk("reset busy_o", int'(busy_o), 0);
      chk("reset dispense_o", int'(dispense_o), 0);
      chk("reset change_valid_o", int'(change_valid_o), 0);
      chk("reset coin_reject_o", int'(coin_reject_o), 0);
      chk("reset sel_err_o", int'(sel_err_o), 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      model_reset();

      // 50 + 25, buy item 1 (75), zero change
      step(1'b1, 50, 1'b0, 0, 1'b0);
      step(1'b1, 25, 1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b1, 1, 1'b0);
      idle(6);
      // 100 + 100, buy item 0 (50), change 150
      step(1'b1, 100, 1'b0, 0, 1'b0);
      step(1'b1, 100, 1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b1, 0, 1'b0);
      idle(6);
      // 50, item 3 refused, cancel refunds 50
      step(1'b1, 50, 1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b1, 3, 1'b0);
      idle(1);
      step(1'b0, 0, 1'b0, 0, 1'b1);
      idle(3);
      // 200 then 100 overflows; coin + cancel together: cancel wins
      step(1'b1, 200, 1'b0, 0, 1'b0);
      step(1'b1, 100, 1'b0, 0, 1'b0);
      step(1'b1, 10, 1'b0, 0, 1'b1);
      idle(3);
      // coin and cancel during dispense are refused/ignored
      step(1'b1, 100, 1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b1, 1, 1'b0);
      step(1'b1, 10, 1'b0, 0, 1'b1);
      idle(5);
      // cancel in idle with nothing else: no pulses
      step(1'b0, 0, 1'b0, 0, 1'b1);
      idle(2);

      for (int i = 0; i < 2500; i++) begin
         step($urandom_range(0, 99) < 35, coin_tab[$urandom_range(0, 6)],
              $urandom_range(0, 99) < 12, int'($urandom_range(0, 3)),
              $urandom_range(0, 99) < 5);
      end
      idle(6);

      // Reset during the second dispense cycle aborts without change
      step(1'b1, 100, 1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b1, 2, 1'b0);
      idle(1);
      @(posedge clk_i);
      #3;
      rst_i = 1'b1;
      #1;
      chk("abort dispense_o", int'(dispense_o), 0);
      chk("abort total_o", int'(total_o), 0);
      chk("abort busy_o", int'(busy_o), 0);
      chk("abort change_valid_o", int'(change_valid_o), 0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      exp_q.delete();
      model_reset();
      idle(6);

      @(posedge clk_i);
      #2;
      chk("scoreboard drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
